// File: rtl/gray_pkg.sv
// gray_pkg
//   Shared Gray-code helpers for gray_count_gen (encode direction) and the
//   gray_to_binary decoder (decode direction).
//   Contents:
//     GRAY_W_DEFAULT : default counter / code width
//     bin2gray()     : binary -> Gray, operates on a zero-extended 32-bit value
//     gray2bin()     : Gray -> binary, operates on a zero-extended 32-bit value
//   Both functions work for any width up to 32 when the caller zero-extends
//   the argument and truncates the result back to its own width.
package gray_pkg;

  localparam int GRAY_W_DEFAULT = 4;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero-extended upper bits leave the
  // result unaffected.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_count_gen_encode.sv
// gray_encode
//   Combinational N-bit binary-to-Gray encoder.
//   Parameters:
//     N    : code width (2..32)
//   Ports:
//     bin  : in  [N-1:0] binary value
//     gray : out [N-1:0] Gray code of bin
module gray_encode
  import gray_pkg::*;
#(
  parameter int N = GRAY_W_DEFAULT
) (
  input  logic [N-1:0] bin,
  output logic [N-1:0] gray
);

  assign gray = N'(bin2gray(32'(bin)));

endmodule

// File: rtl/gray_count_gen.sv
// gray_count_gen
//   Registered up/down binary counter with a registered Gray-code output,
//   intended as a pointer source for async FIFOs and position encoders.
//   The Gray register is loaded from the encoded next-count value, so
//   bin_out and gray_out always change on the same edge and gray_out is
//   glitch-free for synchronizers.
//   Parameters:
//     N        : counter width (2..32)
//   Ports:
//     clk      : in  clock, rising edge
//     rst_n    : in  asynchronous active-low reset
//     en       : in  count enable, one step per cycle
//     up_dn    : in  1 = increment, 0 = decrement (used when en=1)
//     load     : in  synchronous load, takes priority over en
//     load_val : in  [N-1:0] binary load value
//     bin_out  : out [N-1:0] current count, binary
//     gray_out : out [N-1:0] current count, Gray
//     wrap     : out one-cycle pulse on wrap-around (max->0 or 0->max)
//     err      : out sticky Gray-adjacency error flag
//   Optional build macro:
//     GRAY_CHECK_EN : when defined, every counting edge compares the old and
//                     new gray_out; a change of other than exactly one bit
//                     sets err until rst_n. Undefined: err is tied low.
module gray_count_gen
  import gray_pkg::*;
#(
  parameter int N = GRAY_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         up_dn,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] bin_out,
  output logic [N-1:0] gray_out,
  output logic         wrap,
  output logic         err
);

  localparam logic [N-1:0] ALL_ONES = '1;
  localparam logic [N-1:0] ZERO     = '0;

  logic [N-1:0] bin_q;
  logic [N-1:0] gray_q;
  logic         wrap_q;
  logic [N-1:0] bin_nxt;
  logic [N-1:0] gray_nxt;
  logic         wrap_nxt;
  logic         step;
  logic         upd;

  // Next-count selection: load, then count, then hold.
  always_comb begin
    bin_nxt  = bin_q;
    wrap_nxt = 1'b0;
    step     = 1'b0;
    upd      = 1'b0;
    if (load) begin
      bin_nxt = load_val;
      upd     = 1'b1;
    end else if (en) begin
      step = 1'b1;
      upd  = 1'b1;
      if (up_dn) begin
        bin_nxt  = bin_q + N'(1);
        wrap_nxt = (bin_q == ALL_ONES);
      end else begin
        bin_nxt  = bin_q - N'(1);
        wrap_nxt = (bin_q == ZERO);
      end
    end
  end

  gray_encode #(.N(N)) u_encode (
    .bin  (bin_nxt),
    .gray (gray_nxt)
  );

  // Count / Gray / wrap registers. The Gray register only moves on load or
  // count edges so it tracks commanded steps, not the binary register alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_nxt;
      wrap_q <= wrap_nxt;
      if (upd) begin
        gray_q <= gray_nxt;
      end
    end
  end

  assign bin_out  = bin_q;
  assign gray_out = gray_q;
  assign wrap     = wrap_q;

`ifdef GRAY_CHECK_EN
  logic         err_q;
  logic [N-1:0] gray_diff;

  assign gray_diff = gray_q ^ gray_nxt;

  // Adjacency checker: only counting edges must move exactly one Gray bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (step && ($countones(gray_diff) != 1)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_count_gen.sv
module tb_gray_count_gen;

  localparam int N = 4;

`ifdef GRAY_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         up_dn;
  logic         load;
  logic [N-1:0] load_val;
  logic [N-1:0] bin_out;
  logic [N-1:0] gray_out;
  logic         wrap;
  logic         err;

  always #5 clk = ~clk;

  gray_count_gen #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .bin_out  (bin_out),
    .gray_out (gray_out),
    .wrap     (wrap),
    .err      (err)
  );

  // Reference encoder instance, cross-checked against a direct formula.
  logic [N-1:0] ref_bin;
  logic [N-1:0] ref_gray;
  gray_encode #(.N(N)) u_ref (
    .bin  (ref_bin),
    .gray (ref_gray)
  );

  typedef struct packed {
    logic [N-1:0] bin;
    logic [N-1:0] gray;
    logic         wrap;
    logic         err;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];

  int checks   = 0;
  int failures = 0;

  logic [N-1:0] m_bin;
  logic [N-1:0] m_gray;
  logic         m_err;

  function automatic logic [N-1:0] enc(input logic [N-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bin  = '0;
    m_gray = '0;
    m_err  = 1'b0;
  endtask

  // Drive one command at the falling edge, push the expected result, then
  // pop and compare it one time unit after the rising edge.
  task automatic step(input logic e, input logic u, input logic l,
                      input logic [N-1:0] v, input string tag);
    exp_t         x;
    exp_t         got;
    string        t;
    logic [N-1:0] nb;
    logic [N-1:0] ng;
    logic         w;
    en = e; up_dn = u; load = l; load_val = v;
    w = 1'b0;
    if (l) begin
      m_bin  = v;
      m_gray = enc(v);
    end else if (e) begin
      nb = u ? m_bin + 4'd1 : m_bin - 4'd1;
      w  = u ? (m_bin == 4'hF) : (m_bin == 4'h0);
      ng = enc(nb);
      if (CHK && ($countones(m_gray ^ ng) != 1)) m_err = 1'b1;
      m_bin  = nb;
      m_gray = ng;
    end
    x.bin = m_bin; x.gray = m_gray; x.wrap = w; x.err = m_err;
    ref_bin = m_bin;
    sb_q.push_back(x);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    t   = tag_q.pop_front();
    check_val({t, "_bin"},  32'(bin_out),  32'(got.bin));
    check_val({t, "_gray"}, 32'(gray_out), 32'(got.gray));
    check_val({t, "_wrap"}, 32'(wrap),     32'(got.wrap));
    check_val({t, "_err"},  32'(err),      32'(got.err));
    check_val({t, "_refenc"}, 32'(ref_gray), 32'(enc(ref_bin)));
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; up_dn = 1'b0; load = 1'b0; load_val = '0;
    ref_bin = '0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_bin",  32'(bin_out),  32'h0);
    check_val("rst_gray", 32'(gray_out), 32'h0);
    check_val("rst_wrap", 32'(wrap),     32'h0);
    check_val("rst_err",  32'(err),      32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Count up through wrap
    for (int i = 1; i <= 17; i++) begin
      step(1'b1, 1'b1, 1'b0, 4'h0, "up");
      if (i == 15) check_val("up15_gray", 32'(gray_out), 32'b1000);
      if (i == 16) begin
        check_val("up16_gray", 32'(gray_out), 32'b0000);
        check_val("up16_wrap", 32'(wrap), 32'h1);
      end
    end

    // Count down through zero
    step(1'b0, 1'b0, 1'b1, 4'b0010, "ld2");
    check_val("ld2_gray", 32'(gray_out), 32'b0011);
    step(1'b1, 1'b0, 1'b0, 4'h0, "dn");
    step(1'b1, 1'b0, 1'b0, 4'h0, "dn");
    step(1'b1, 1'b0, 1'b0, 4'h0, "dn");
    check_val("dn_bin_f",  32'(bin_out),  32'b1111);
    check_val("dn_gray_f", 32'(gray_out), 32'b1000);
    check_val("dn_wrap_f", 32'(wrap),     32'h1);
    step(1'b1, 1'b0, 1'b0, 4'h0, "dn");
    check_val("dn_gray_e", 32'(gray_out), 32'b1001);

    // Load beats enable
    step(1'b1, 1'b1, 1'b1, 4'b1011, "ldpri");
    check_val("ldpri_bin",  32'(bin_out),  32'b1011);
    check_val("ldpri_gray", 32'(gray_out), 32'b1110);

    // Load of current value holds, no wrap
    step(1'b0, 1'b0, 1'b1, 4'b1011, "ldsame");

    // Hold and direction flip
    step(1'b0, 1'b0, 1'b1, 4'b0101, "ld5");
    step(1'b1, 1'b1, 1'b0, 4'h0, "flip_up");
    check_val("flip_up_bin", 32'(bin_out), 32'b0110);
    step(1'b0, 1'b1, 1'b0, 4'h0, "flip_hold");
    check_val("flip_hold_bin", 32'(bin_out), 32'b0110);
    step(1'b1, 1'b0, 1'b0, 4'h0, "flip_dn");
    check_val("flip_dn_bin", 32'(bin_out), 32'b0101);

    // Async reset mid-count
    step(1'b0, 1'b0, 1'b1, 4'b1001, "ld9");
    en = 1'b1; up_dn = 1'b1; load = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_bin",  32'(bin_out),  32'h0);
    check_val("arst_gray", 32'(gray_out), 32'h0);
    check_val("arst_wrap", 32'(wrap),     32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b0, 4'h0, "post_rst");
    check_val("post_rst_bin", 32'(bin_out), 32'b0001);

    // Corrupt the binary register by 2 and take a counting step
    step(1'b0, 1'b0, 1'b1, 4'b0001, "ld1");
    force dut.bin_q = 4'b0011;
    m_bin = 4'b0011;
    step(1'b0, 1'b0, 1'b0, 4'h0, "forced_hold");
    release dut.bin_q;
    step(1'b1, 1'b1, 1'b0, 4'h0, "corrupt");
    check_val("corrupt_err", 32'(err), 32'(CHK));
    step(1'b0, 1'b0, 1'b0, 4'h0, "sticky");
    step(1'b1, 1'b1, 1'b0, 4'h0, "sticky_cnt");
    rst_n = 1'b0;
    #1;
    check_val("err_clr", 32'(err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
